// File: rtl/montador_entrada.sv
// Serial-to-parallel word assembler with valid/ready hold, idle timeout and optional parity.
// Optional feature: define MONTADOR_PARIDADE_EN to expect an even-parity 9th bit per word.
module montador_entrada #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_serial_in,
  input  logic i_serial_valid,
  input  logic i_pronto,
  output logic o_b8,
  output logic o_b7,
  output logic o_b6,
  output logic o_b5,
  output logic o_b4,
  output logic o_b3,
  output logic o_b2,
  output logic o_b1,
  output logic o_palavra_valida,
  output logic o_ocupado,
  output logic o_erro
);

  localparam int unsigned W_WORD = 8;
  localparam int unsigned W_CNT  = 4;
  localparam int unsigned W_IDLE = 8;

  typedef enum logic [1:0] {
    OCIOSO     = 2'd0,
    RECEBENDO  = 2'd1,
    AGUARDANDO = 2'd2
  } state_t;

  state_t              r_state;
  logic [W_WORD-1:0]   r_sr;
  logic [W_WORD-1:0]   r_word;
  logic [W_CNT-1:0]    r_cnt;
  logic [W_IDLE-1:0]   r_idle;
  logic                r_pv;
  logic                r_ocupado;
  logic                r_erro;
  logic [W_WORD-1:0]   w_sr_next;

  assign w_sr_next = {r_sr[W_WORD-2:0], i_serial_in};

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state   <= OCIOSO;
      r_sr      <= '0;
      r_word    <= '0;
      r_cnt     <= '0;
      r_idle    <= '0;
      r_pv      <= 1'b0;
      r_ocupado <= 1'b0;
      r_erro    <= 1'b0;
    end else begin
      r_erro <= 1'b0;
      case (r_state)
        OCIOSO: begin
          if (i_serial_valid) begin
            r_sr    <= w_sr_next;
            r_cnt   <= W_CNT'(1);
            r_idle  <= '0;
            r_state <= RECEBENDO;
          end
        end

        RECEBENDO: begin
          if (i_serial_valid) begin
            r_idle <= '0;
`ifdef MONTADOR_PARIDADE_EN
            // 9th bit is parity: data is already complete in r_sr
            if (r_cnt == W_CNT'(8)) begin
              r_cnt <= '0;
              if ((^{r_sr, i_serial_in}) == 1'b0) begin
                r_word    <= r_sr;
                r_pv      <= 1'b1;
                r_ocupado <= 1'b1;
                r_state   <= AGUARDANDO;
              end else begin
                r_sr    <= '0;
                r_erro  <= 1'b1;
                r_state <= OCIOSO;
              end
            end else begin
              r_sr  <= w_sr_next;
              r_cnt <= r_cnt + W_CNT'(1);
            end
`else
            r_sr <= w_sr_next;
            if (r_cnt == W_CNT'(7)) begin
              r_word    <= w_sr_next;
              r_cnt     <= '0;
              r_pv      <= 1'b1;
              r_ocupado <= 1'b1;
              r_state   <= AGUARDANDO;
            end else begin
              r_cnt <= r_cnt + W_CNT'(1);
            end
`endif
          end else if (r_idle == W_IDLE'(TIMEOUT - 1)) begin
            // abort lands on the TIMEOUT-th idle edge
            r_idle  <= '0;
            r_cnt   <= '0;
            r_sr    <= '0;
            r_erro  <= 1'b1;
            r_state <= OCIOSO;
          end else begin
            r_idle <= r_idle + W_IDLE'(1);
          end
        end

        AGUARDANDO: begin
          if (i_pronto) begin
            r_pv      <= 1'b0;
            r_ocupado <= 1'b0;
            r_state   <= OCIOSO;
          end
        end

        default: r_state <= OCIOSO;
      endcase
    end
  end

  assign {o_b8, o_b7, o_b6, o_b5, o_b4, o_b3, o_b2, o_b1} = r_word;
  assign o_palavra_valida = r_pv;
  assign o_ocupado        = r_ocupado;
  assign o_erro           = r_erro;

endmodule

// File: tb/tb_montador_entrada.sv
// Scoreboard bench for montador_entrada: directed words, back-pressure, timeout, reset, parity.
module tb_montador_entrada;

  logic clk = 1'b0;
  logic i_reset = 1'b1;
  logic i_serial_in = 1'b0;
  logic i_serial_valid = 1'b0;
  logic i_pronto = 1'b0;
  logic o_b8, o_b7, o_b6, o_b5, o_b4, o_b3, o_b2, o_b1;
  logic o_palavra_valida, o_ocupado, o_erro;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       is_err;
    logic [7:0] word;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  montador_entrada #(.TIMEOUT(15)) dut (
    .i_clk(clk), .i_reset(i_reset), .i_serial_in(i_serial_in),
    .i_serial_valid(i_serial_valid), .i_pronto(i_pronto),
    .o_b8(o_b8), .o_b7(o_b7), .o_b6(o_b6), .o_b5(o_b5),
    .o_b4(o_b4), .o_b3(o_b3), .o_b2(o_b2), .o_b1(o_b1),
    .o_palavra_valida(o_palavra_valida), .o_ocupado(o_ocupado), .o_erro(o_erro)
  );

  function automatic logic [7:0] word_out();
    return {o_b8, o_b7, o_b6, o_b5, o_b4, o_b3, o_b2, o_b1};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    i_serial_valid = 1'b1;
    i_serial_in    = b;
    tick();
    i_serial_valid = 1'b0;
  endtask

  task automatic send_data(input logic [7:0] w);
    for (int i = 7; i >= 0; i--) send_bit(w[i]);
  endtask

  // full word including the parity bit when the parity build is active
  task automatic send_word(input logic [7:0] w);
    exp_q.push_back('{is_err: 1'b0, word: w});
    send_data(w);
`ifdef MONTADOR_PARIDADE_EN
    send_bit(^w);
`endif
    chk("word_out", 32'(word_out()), 32'(w));
    chk("pv_after_word", 32'(o_palavra_valida), 32'd1);
    chk("ocupado_after_word", 32'(o_ocupado), 32'd1);
  endtask

  task automatic transfer(input logic bit_offered);
    i_pronto       = 1'b1;
    i_serial_valid = bit_offered;
    i_serial_in    = 1'b1;
    tick();
    i_pronto       = 1'b0;
    i_serial_valid = 1'b0;
    chk("pv_after_xfer", 32'(o_palavra_valida), 32'd0);
    chk("ocupado_after_xfer", 32'(o_ocupado), 32'd0);
  endtask

  task automatic chk_all_zero(input string name);
    chk(name, 32'({word_out(), o_palavra_valida, o_ocupado, o_erro}), 32'd0);
  endtask

  // monitor: pops expected events whenever the DUT presents a new word or an error pulse
  initial begin : monitor
    logic       prev_pv;
    logic       prev_erro;
    logic [7:0] held;
    exp_t       e;
    prev_pv   = 1'b0;
    prev_erro = 1'b0;
    held      = 8'h00;
    forever begin
      @(negedge clk);
      if (o_palavra_valida && !prev_pv) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL mon_word: unexpected word %0h", word_out());
        end else begin
          e = exp_q.pop_front();
          chk("mon_word_kind", 32'(e.is_err), 32'd0);
          chk("mon_word", 32'(word_out()), 32'(e.word));
        end
        held = word_out();
      end else if (o_palavra_valida && prev_pv) begin
        chk("mon_word_stable", 32'(word_out()), 32'(held));
      end
      if (o_erro) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL mon_erro: unexpected erro pulse got 1 expected 0");
        end else begin
          e = exp_q.pop_front();
          chk("mon_erro_kind", 32'(e.is_err), 32'd1);
        end
        chk("mon_erro_single", 32'(prev_erro), 32'd0);
      end
      prev_pv   = o_palavra_valida;
      prev_erro = o_erro;
    end
  end

  initial begin : stim
    logic [7:0] prev;
    tick(); tick();
    chk_all_zero("reset_state");
    i_reset = 1'b0;

    // basic word with pronto low, held then transferred
    send_word(8'b11011000);
    tick(); tick();
    chk("hold_pv", 32'(o_palavra_valida), 32'd1);
    chk("hold_word", 32'(word_out()), 32'hD8);
    transfer(1'b0);

    // back-pressure: bits offered while busy are lost
    send_word(8'b11101011);
    for (int i = 0; i < 5; i++) begin
      send_bit(((i % 2) == 0) ? 1'b1 : 1'b0);
      chk("bp_word", 32'(word_out()), 32'hEB);
      chk("bp_pv", 32'(o_palavra_valida), 32'd1);
    end
    transfer(1'b1);
    send_word(8'b11001111);
    transfer(1'b0);

    // timeout: erro exactly 15 edges after the 3rd bit
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
    exp_q.push_back('{is_err: 1'b1, word: 8'h00});
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk("to_erro", 32'(o_erro), (i == 15) ? 32'd1 : 32'd0);
    end
    tick();
    chk("to_erro_drop", 32'(o_erro), 32'd0);
    chk("to_word_kept", 32'(word_out()), 32'hCF);
    chk("to_pv", 32'(o_palavra_valida), 32'd0);
    send_word(8'b10100011);
    transfer(1'b0);

    // idle boundary: 14 idle cycles do not abort
    exp_q.push_back('{is_err: 1'b0, word: 8'hD2});
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b0);
    for (int i = 0; i < 14; i++) tick();
    chk("idle_no_erro", 32'(o_erro), 32'd0);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
`ifdef MONTADOR_PARIDADE_EN
    send_bit(1'b0);
`endif
    chk("idle_word", 32'(word_out()), 32'hD2);
    chk("idle_pv", 32'(o_palavra_valida), 32'd1);
    transfer(1'b0);

    // reset mid-word and reset with a pending word
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
    i_reset = 1'b1; tick(); i_reset = 1'b0;
    chk_all_zero("reset_midword");
    send_word(8'hA5);
    i_reset = 1'b1; tick(); i_reset = 1'b0;
    chk_all_zero("reset_pending");
    send_word(8'b00100010);
    transfer(1'b0);

    // minimum word period with pronto tied high
    i_pronto = 1'b1;
    send_word(8'h3C);
    tick();
    chk("minp_pv_drop", 32'(o_palavra_valida), 32'd0);
    send_word(8'hC3);
    tick();
    chk("minp_pv_drop2", 32'(o_palavra_valida), 32'd0);
    i_pronto = 1'b0;

`ifdef MONTADOR_PARIDADE_EN
    send_word(8'b10100011);
    transfer(1'b0);
    prev = word_out();
    exp_q.push_back('{is_err: 1'b1, word: 8'h00});
    send_data(8'b10100011);
    send_bit(1'b1);
    chk("par_erro", 32'(o_erro), 32'd1);
    chk("par_pv", 32'(o_palavra_valida), 32'd0);
    chk("par_word_kept", 32'(word_out()), 32'(prev));
    tick();
    chk("par_erro_drop", 32'(o_erro), 32'd0);
`else
    prev = 8'h00;
`endif

    for (int i = 0; i < 4; i++) tick();
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
